// File: rtl/asic_iobuf_seq.sv
// Power-up and retention sequencer for a bank of GPIO pads.
// Drives each pad's tech_cfg control bits (HLD_H_N, ENABLE_H, ENABLE_INP_H) and gates user config.
module asic_iobuf_seq #(
    parameter int unsigned NPADS          = 4,
    parameter int unsigned TECH_CFG_WIDTH = 16,
    parameter int unsigned ENABLE_DLY     = 8,
    parameter int unsigned HOLD_DLY       = 4,
    parameter logic [15:0] SAFE_CFG       = 16'h0
) (
    input  logic                            clk,
    input  logic                            nreset,
    input  logic [NPADS*TECH_CFG_WIDTH-1:0] user_cfg,
    input  logic                            hold_req,
    output logic                            hold_ack,
    output logic                            ready,
    output logic [NPADS*TECH_CFG_WIDTH-1:0] tech_cfg
);

    localparam int unsigned W       = TECH_CFG_WIDTH;
    localparam int unsigned UW      = W - 3;
    localparam int unsigned MAX_DLY = (ENABLE_DLY > HOLD_DLY) ? ENABLE_DLY : HOLD_DLY;
    localparam int unsigned CNT_W   = $clog2(MAX_DLY + 1);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] ENA_END = CNT_W'(ENABLE_DLY - 1);
    localparam logic [CNT_W-1:0] HLD_END = CNT_W'(HOLD_DLY - 1);
    localparam logic [UW-1:0]    SAFE_UP = UW'(SAFE_CFG[15:3]);

    localparam logic [2:0] ST_OFF      = 3'd0;
    localparam logic [2:0] ST_WAIT_HLD = 3'd1;
    localparam logic [2:0] ST_ACTIVE   = 3'd2;
    localparam logic [2:0] ST_HOLD_ENT = 3'd3;
    localparam logic [2:0] ST_HOLD     = 3'd4;
    localparam logic [2:0] ST_HOLD_EXT = 3'd5;

    logic [2:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ready_q, ready_d;
    logic                hold_ack_q, hold_ack_d;
    logic [2:0]          ctrl_q, ctrl_d;     // {ENABLE_INP_H, ENABLE_H, HLD_H_N}
    logic [NPADS*UW-1:0] upper_q, upper_d;   // per-pad tech_cfg[W-1:3]
    logic [NPADS*3-1:0]  unused_low;

    // State, counter and output registers
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q    <= ST_OFF;
            cnt_q      <= '0;
            ready_q    <= 1'b0;
            hold_ack_q <= 1'b0;
            ctrl_q     <= 3'b000;
            upper_q    <= {NPADS{SAFE_UP}};
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ready_q    <= ready_d;
            hold_ack_q <= hold_ack_d;
            ctrl_q     <= ctrl_d;
            upper_q    <= upper_d;
        end
    end

    // Next state, counter and next registered outputs
    always_comb begin
        state_d    = state_q;
        cnt_d      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        ready_d    = 1'b0;
        hold_ack_d = 1'b0;
        ctrl_d     = 3'b000;
        upper_d    = {NPADS{SAFE_UP}};

        case (state_q)
            ST_OFF:      if (cnt_q == ENA_END) state_d = ST_WAIT_HLD;
            ST_WAIT_HLD: if (cnt_q == HLD_END) state_d = ST_ACTIVE;
            ST_ACTIVE:   if (hold_req)         state_d = ST_HOLD_ENT;
            ST_HOLD_ENT: if (cnt_q == HLD_END) state_d = ST_HOLD;
            ST_HOLD:     if (!hold_req)        state_d = ST_HOLD_EXT;
            ST_HOLD_EXT: if (cnt_q == HLD_END) state_d = ST_ACTIVE;
            default:                           state_d = ST_OFF;
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end

        // Outputs follow the state being entered so they change on the transition edge
        case (state_d)
            ST_WAIT_HLD: begin
                ctrl_d = 3'b010;
            end
            ST_ACTIVE: begin
                ready_d = 1'b1;
                ctrl_d  = 3'b111;
                for (int unsigned i = 0; i < NPADS; i++) begin
                    upper_d[i*UW +: UW] = user_cfg[i*W+3 +: UW];
                end
            end
            ST_HOLD_ENT: begin
                ctrl_d  = 3'b110;
                upper_d = upper_q;
            end
            ST_HOLD, ST_HOLD_EXT: begin
                hold_ack_d = 1'b1;
                ctrl_d     = 3'b110;
                upper_d    = upper_q;
            end
            default: begin
                ctrl_d = 3'b000;
            end
        endcase
    end

    // Control bits are regenerated here, so the user's low three bits are never used
    for (genvar g = 0; g < NPADS; g++) begin : g_pad
        assign tech_cfg[g*W +: W]  = {upper_q[g*UW +: UW], ctrl_q};
        assign unused_low[g*3 +: 3] = user_cfg[g*W +: 3];
    end

    assign ready    = ready_q;
    assign hold_ack = hold_ack_q;

endmodule

// File: tb/tb_asic_iobuf_seq.sv
// Bench for asic_iobuf_seq: directed vector table, glitch/reset sequences,
// then randomized traffic against a countdown-timer mode model.
module tb_asic_iobuf_seq;

    localparam int unsigned NP = 2;
    localparam int unsigned W  = 16;
    localparam int ENA = 4;
    localparam int HLD = 2;

    logic              clk;
    logic              nreset;
    logic [NP*W-1:0]   user_cfg;
    logic              hold_req;
    logic              hold_ack;
    logic              ready;
    logic [NP*W-1:0]   tech_cfg;

    asic_iobuf_seq #(
        .NPADS(NP), .TECH_CFG_WIDTH(W), .ENABLE_DLY(ENA), .HOLD_DLY(HLD), .SAFE_CFG(16'h0)
    ) dut (
        .clk(clk), .nreset(nreset), .user_cfg(user_cfg), .hold_req(hold_req),
        .hold_ack(hold_ack), .ready(ready), .tech_cfg(tech_cfg)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        else
            passed++;
    endtask

    // Behavioural model: operating mode plus a countdown of cycles left in it
    localparam int M_OFF = 0, M_POWER = 1, M_RUN = 2, M_FREEZE = 3, M_FROZEN = 4, M_THAW = 5;
    int          m_mode  = M_OFF;
    int          m_left  = ENA;
    logic [15:0] m_cfg [NP];

    task automatic m_step(input logic n, input logic h, input logic [15:0] c0, input logic [15:0] c1);
        if (!n) begin
            m_mode = M_OFF;
            m_left = ENA;
        end else begin
            case (m_mode)
                M_OFF:    begin m_left--; if (m_left == 0) begin m_mode = M_POWER; m_left = HLD; end end
                M_POWER:  begin m_left--; if (m_left == 0) m_mode = M_RUN; end
                M_RUN:    if (h) begin m_mode = M_FREEZE; m_left = HLD; end
                M_FREEZE: begin m_left--; if (m_left == 0) m_mode = M_FROZEN; end
                M_FROZEN: if (!h) begin m_mode = M_THAW; m_left = HLD; end
                default:  begin m_left--; if (m_left == 0) m_mode = M_RUN; end
            endcase
            if (m_mode == M_RUN) begin
                m_cfg[0] = c0;
                m_cfg[1] = c1;
            end
        end
    endtask

    function automatic logic [15:0] m_pad(input int i);
        logic       live;
        logic [2:0] lo;
        live = (m_mode >= M_RUN);
        lo   = {live, m_mode != M_OFF, m_mode == M_RUN};
        return live ? {m_cfg[i][15:3], lo} : {13'h0, lo};
    endfunction

    task automatic m_check(input string tag);
        chk({tag, "_ready"}, 32'(ready), 32'(m_mode == M_RUN));
        chk({tag, "_ack"}, 32'(hold_ack), 32'(m_mode == M_FROZEN || m_mode == M_THAW));
        chk({tag, "_tech"}, tech_cfg, {m_pad(1), m_pad(0)});
    endtask

    // Apply one cycle of inputs, advance the model on the same edge, sample 1ns later
    task automatic step(input logic n, input logic h, input logic [15:0] c0, input logic [15:0] c1);
        nreset   = n;
        hold_req = h;
        user_cfg = {c1, c0};
        @(posedge clk);
        #1;
        m_step(n, h, c0, c1);
    endtask

    typedef struct {
        logic        n;
        logic        h;
        logic [15:0] c0;
        logic [15:0] c1;
        logic        rdy;
        logic        ack;
        logic [15:0] t0;
        logic [15:0] t1;
    } vec_t;

    vec_t tbl [15];

    initial begin
        int ack_cycles;
        int en_edge;
        int rdy_edge;
        logic h;

        clk      = 1'b0;
        nreset   = 1'b0;
        hold_req = 1'b0;
        user_cfg = '0;
        m_cfg[0] = 16'h0;
        m_cfg[1] = 16'h0;

        // Power-up, passthrough, hold entry and release
        tbl[0]  = '{1'b0, 1'b0, 16'hE003, 16'hE003, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[1]  = '{1'b1, 1'b0, 16'hE003, 16'hE003, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[2]  = '{1'b1, 1'b0, 16'hE003, 16'hE003, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[3]  = '{1'b1, 1'b0, 16'hE003, 16'hE003, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[4]  = '{1'b1, 1'b0, 16'hE003, 16'hE003, 1'b0, 1'b0, 16'h0002, 16'h0002};
        tbl[5]  = '{1'b1, 1'b0, 16'hE003, 16'hE003, 1'b0, 1'b0, 16'h0002, 16'h0002};
        tbl[6]  = '{1'b1, 1'b0, 16'hE003, 16'hE003, 1'b1, 1'b0, 16'hE007, 16'hE007};
        tbl[7]  = '{1'b1, 1'b0, 16'hE003, 16'h6100, 1'b1, 1'b0, 16'hE007, 16'h6107};
        tbl[8]  = '{1'b1, 1'b1, 16'hE003, 16'h6100, 1'b0, 1'b0, 16'hE006, 16'h6106};
        tbl[9]  = '{1'b1, 1'b1, 16'h1234, 16'h5678, 1'b0, 1'b0, 16'hE006, 16'h6106};
        tbl[10] = '{1'b1, 1'b1, 16'h1234, 16'h5678, 1'b0, 1'b1, 16'hE006, 16'h6106};
        tbl[11] = '{1'b1, 1'b1, 16'h1234, 16'h5678, 1'b0, 1'b1, 16'hE006, 16'h6106};
        tbl[12] = '{1'b1, 1'b0, 16'hA5A8, 16'h3C38, 1'b0, 1'b1, 16'hE006, 16'h6106};
        tbl[13] = '{1'b1, 1'b0, 16'hA5A8, 16'h3C38, 1'b0, 1'b1, 16'hE006, 16'h6106};
        tbl[14] = '{1'b1, 1'b0, 16'hA5A8, 16'h3C38, 1'b1, 1'b0, 16'hA5AF, 16'h3C3F};

        for (int i = 0; i < 15; i++) begin
            step(tbl[i].n, tbl[i].h, tbl[i].c0, tbl[i].c1);
            chk($sformatf("vec%0d_ready", i), 32'(ready), 32'(tbl[i].rdy));
            chk($sformatf("vec%0d_ack", i), 32'(hold_ack), 32'(tbl[i].ack));
            chk($sformatf("vec%0d_pad0", i), 32'(tech_cfg[15:0]), 32'(tbl[i].t0));
            chk($sformatf("vec%0d_pad1", i), 32'(tech_cfg[31:16]), 32'(tbl[i].t1));
        end

        // One-cycle hold_req glitch still runs a full entry/hold/exit
        ack_cycles = 0;
        step(1'b1, 1'b1, 16'hA5A8, 16'h3C38);
        m_check("glitch_enter");
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 16'h0F08, 16'hF0F0);
            m_check($sformatf("glitch%0d", i));
            if (hold_ack) ack_cycles++;
        end
        chk("glitch_ack_cycles", 32'(ack_cycles), 32'd3);
        chk("glitch_ready_back", 32'(ready), 32'd1);
        chk("glitch_cfg_back", tech_cfg, 32'h F0F7_0F0F);

        // Reset while frozen, then power-up timing repeats from release
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 16'h1111, 16'h2222);
        chk("pre_reset_in_hold", 32'(hold_ack), 32'd1);
        step(1'b0, 1'b1, 16'hE003, 16'hE003);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_ack", 32'(hold_ack), 32'd0);
        chk("rst_tech", tech_cfg, 32'h0);
        en_edge  = -1;
        rdy_edge = -1;
        for (int e = 1; e <= 8; e++) begin
            step(1'b1, 1'b0, 16'hE003, 16'hE003);
            m_check($sformatf("repower%0d", e));
            if (en_edge < 0 && tech_cfg[1]) en_edge = e;
            if (rdy_edge < 0 && ready) rdy_edge = e;
        end
        chk("repower_enable_edge", 32'(en_edge), 32'd4);
        chk("repower_ready_edge", 32'(rdy_edge), 32'd6);

        // Randomized traffic: level hold_req with occasional toggles, rare resets
        h = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) h = ~h;
            step($urandom_range(0, 79) != 0, h, 16'($urandom), 16'($urandom));
            m_check($sformatf("rnd%0d", i));
            chk($sformatf("rnd%0d_excl", i), 32'(ready & hold_ack), 32'd0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
